// File: rtl/pim_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pim_seq_ctrl
// Purpose  : Sequencer for a processing-in-memory macro. It decodes bus
//            accesses into weight and activation beats, steps word-line
//            writes, runs the fixed-length compute and result-wait phases,
//            and holds the result-valid, sticky error and done-interrupt
//            status.
// Ports    : i_clk, i_rst_n (synchronous, active-low)
//            i_valid, i_address           - bus access strobe / address
//            o_weight_in_en/out_en/sel    - weight beat accept, WL write, lane
//            o_WL_address                 - current word line
//            o_activation_in_en/out_en/sel- activation accept, push, lane
//            o_result_in_en/out_en        - result capture / result read
//            o_counter                    - phase counter (saturating)
//            o_busy, o_valid, o_err, o_irq- status
// Revision : 1.0 - initial release
// ============================================================================
module pim_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int          N_LANES      = 4,
  parameter int          WL_DEPTH     = 288,
  parameter int          WORDS_PER_WL = 16,
  parameter int          ACT_WORDS    = 72,
  parameter int          COMP_CYCLES  = 64,
  parameter int          ACT_STRIDE   = 8,
  parameter int          RES_LAT      = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  input  logic [31:0]                 i_address,
  output logic                        o_weight_in_en,
  output logic                        o_weight_out_en,
  output logic [$clog2(N_LANES)-1:0]  o_weight_sel,
  output logic [$clog2(WL_DEPTH)-1:0] o_WL_address,
  output logic                        o_activation_in_en,
  output logic                        o_activation_out_en,
  output logic [$clog2(N_LANES)-1:0]  o_activation_sel,
  output logic                        o_result_in_en,
  output logic                        o_result_out_en,
  output logic [7:0]                  o_counter,
  output logic                        o_busy,
  output logic                        o_valid,
  output logic                        o_err,
  output logic                        o_irq
);

  localparam int c_SEL_W = $clog2(N_LANES);
  localparam int c_WL_W  = $clog2(WL_DEPTH);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_ACT  = 2'd1;
  localparam logic [1:0] c_ST_COMP = 2'd2;
  localparam logic [1:0] c_ST_RES  = 2'd3;

  localparam logic [31:0] c_OFF_STATUS = 32'h10;
  localparam logic [31:0] c_OFF_RESULT = 32'h20;
  localparam logic [31:0] c_OFF_CLEAR  = 32'h30;
  localparam logic [31:0] c_OFF_WGT    = 32'h100;
  localparam logic [31:0] c_OFF_ACT    = 32'h200;
  localparam logic [31:0] c_WGT_END    = 32'h100 + 32'(4 * N_LANES);
  localparam logic [31:0] c_ACT_END    = 32'h200 + 32'(4 * N_LANES);
  localparam logic [31:0] c_WIN_SIZE   = 32'h1000;

  localparam logic [15:0]       c_WPW_LAST  = 16'(WORDS_PER_WL - 1);
  localparam logic [15:0]       c_ACT_LAST  = 16'(ACT_WORDS - 1);
  localparam logic [15:0]       c_COMP_LAST = 16'(COMP_CYCLES - 1);
  localparam logic [15:0]       c_STR_LAST  = 16'(ACT_STRIDE - 1);
  localparam logic [15:0]       c_RES_LAST  = 16'(RES_LAT - 1);
  localparam logic [c_WL_W-1:0] c_WL_LAST   = c_WL_W'(WL_DEPTH - 1);

  logic [1:0]         r_state;
  logic [15:0]        r_wcnt;     // weight beats within the current word line
  logic [15:0]        r_acnt;     // activation beats of the current inference
  logic [15:0]        r_ph_cnt;   // cycle count inside COMP / RES
  logic [15:0]        r_str_cnt;  // position inside the activation stride
  logic [c_SEL_W-1:0] r_wsel;
  logic [c_SEL_W-1:0] r_asel;
  logic [c_WL_W-1:0]  r_wl;
  logic               r_wgt_out;
  logic               r_act_out;
  logic               r_res_out;
  logic               r_valid;
  logic               r_err;
  logic               r_irq;

  logic [31:0]        w_off;
  logic               w_in_win;
  logic               w_is_status;
  logic               w_is_rd;
  logic               w_is_clr;
  logic               w_is_wgt;
  logic               w_is_act;
  logic               w_undec;
  logic [c_SEL_W-1:0] w_lane;
  logic               w_busy;
  logic               w_wgt_acc;
  logic               w_act_acc;
  logic               w_res_cap;
  logic               w_err_evt;
  logic [15:0]        w_cnt_sel;

  // Address decode. The window is 4 KiB; the lane index sits in bits above
  // the word offset because the weight/activation bases are 256-aligned.
  always_comb begin
    w_off       = i_address - BASE_ADDR;
    w_in_win    = i_valid && (w_off < c_WIN_SIZE);
    w_is_status = w_in_win && (w_off == c_OFF_STATUS);
    w_is_rd     = w_in_win && (w_off == c_OFF_RESULT);
    w_is_clr    = w_in_win && (w_off == c_OFF_CLEAR);
    w_is_wgt    = w_in_win && (w_off >= c_OFF_WGT) && (w_off < c_WGT_END) &&
                  (w_off[1:0] == 2'b00);
    w_is_act    = w_in_win && (w_off >= c_OFF_ACT) && (w_off < c_ACT_END) &&
                  (w_off[1:0] == 2'b00);
    w_undec     = w_in_win && !(w_is_status || w_is_rd || w_is_clr ||
                                w_is_wgt || w_is_act);
    w_lane      = w_off[c_SEL_W+1:2];
  end

  always_comb begin
    w_busy    = (r_state == c_ST_COMP) || (r_state == c_ST_RES);
    w_wgt_acc = i_rst_n && w_is_wgt && (r_state == c_ST_IDLE);
    w_act_acc = i_rst_n && w_is_act &&
                ((r_state == c_ST_IDLE) || (r_state == c_ST_ACT));
    w_res_cap = (r_state == c_ST_RES) && (r_ph_cnt == c_RES_LAST);
    // Every condition that latches the sticky error; an overrun counts too.
    w_err_evt = w_undec ||
                (w_is_wgt && (r_state != c_ST_IDLE)) ||
                (w_is_act && w_busy) ||
                (w_is_rd && !r_valid) ||
                (w_res_cap && r_valid);
  end

  always_comb begin
    case (r_state)
      c_ST_IDLE: w_cnt_sel = r_wcnt;
      c_ST_ACT:  w_cnt_sel = r_acnt;
      default:   w_cnt_sel = r_ph_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= c_ST_IDLE;
      r_wcnt    <= '0;
      r_acnt    <= '0;
      r_ph_cnt  <= '0;
      r_str_cnt <= '0;
      r_wsel    <= '0;
      r_asel    <= '0;
      r_wl      <= '0;
      r_wgt_out <= 1'b0;
      r_act_out <= 1'b0;
      r_res_out <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_wgt_out <= 1'b0;
      r_act_out <= 1'b0;
      r_res_out <= 1'b0;
      r_irq     <= 1'b0;

      if (w_wgt_acc) begin
        r_wsel <= w_lane;
        if (r_wcnt == c_WPW_LAST) begin
          r_wcnt    <= '0;
          r_wgt_out <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + 16'd1;
        end
      end

      // Word line advances one cycle after its write pulse.
      if (r_wgt_out) begin
        r_wl <= (r_wl == c_WL_LAST) ? '0 : r_wl + 1'b1;
      end

      case (r_state)
        c_ST_IDLE, c_ST_ACT: begin
          if (w_act_acc) begin
            r_asel <= w_lane;
            if (r_acnt == c_ACT_LAST) begin
              r_state   <= c_ST_COMP;
              r_acnt    <= '0;
              r_ph_cnt  <= '0;
              r_str_cnt <= '0;
            end else begin
              r_state <= c_ST_ACT;
              r_acnt  <= r_acnt + 16'd1;
            end
          end
        end
        c_ST_COMP: begin
          // Stride counter tracks counter mod ACT_STRIDE without a divider.
          r_act_out <= (r_str_cnt == c_STR_LAST);
          r_str_cnt <= (r_str_cnt == c_STR_LAST) ? '0 : r_str_cnt + 16'd1;
          if (r_ph_cnt == c_COMP_LAST) begin
            r_state  <= c_ST_RES;
            r_ph_cnt <= '0;
          end else begin
            r_ph_cnt <= r_ph_cnt + 16'd1;
          end
        end
        c_ST_RES: begin
          if (r_ph_cnt == c_RES_LAST) begin
            r_state  <= c_ST_IDLE;
            r_ph_cnt <= '0;
            r_irq    <= 1'b1;
          end else begin
            r_ph_cnt <= r_ph_cnt + 16'd1;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase

      // A fresh capture wins over a read clearing the old result.
      if (w_res_cap) begin
        r_valid <= 1'b1;
      end else if (w_is_rd && r_valid) begin
        r_valid <= 1'b0;
      end
      if (w_is_rd && r_valid) begin
        r_res_out <= 1'b1;
      end

      // A simultaneous error event keeps the flag set over a clear.
      if (w_err_evt) begin
        r_err <= 1'b1;
      end else if (w_is_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_weight_in_en      = w_wgt_acc;
  assign o_weight_out_en     = r_wgt_out;
  assign o_weight_sel        = r_wsel;
  assign o_WL_address        = r_wl;
  assign o_activation_in_en  = w_act_acc;
  assign o_activation_out_en = r_act_out;
  assign o_activation_sel    = r_asel;
  assign o_result_in_en      = w_res_cap;
  assign o_result_out_en     = r_res_out;
  assign o_counter           = (w_cnt_sel > 16'd255) ? 8'hFF : w_cnt_sel[7:0];
  assign o_busy              = w_busy;
  assign o_valid             = r_valid;
  assign o_err               = r_err;
  assign o_irq               = r_irq;

endmodule
`default_nettype wire

// File: doc/pim_seq_ctrl.md
PIM_SEQ_CTRL -- requirements
Module: pim_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BASE_ADDR, 32'h4000_0000, base of the register window.
- N_LANES, 4, number of weight and activation lanes.
- WL_DEPTH, 288, number of word lines.
- WORDS_PER_WL, 16, weight beats per word line.
- ACT_WORDS, 72, activation beats per inference.
- COMP_CYCLES, 64, compute phase length in cycles.
- ACT_STRIDE, 8, compute cycles per activation push.
- RES_LAT, 8, cycles from compute end to result capture.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, reset: synchronous, active-low.
- i_valid, in, 1, bus access strobe.
- i_address, in, 32, bus address.
- o_weight_in_en, out, 1, weight beat accepted.
- o_weight_out_en, out, 1, word-line write pulse.
- o_weight_sel, out, $clog2(N_LANES), lane of the last accepted weight beat.
- o_WL_address, out, $clog2(WL_DEPTH), current word line.
- o_activation_in_en, out, 1, activation beat accepted.
- o_activation_out_en, out, 1, activation push to the array.
- o_activation_sel, out, $clog2(N_LANES), lane of the last accepted activation beat.
- o_result_in_en, out, 1, result capture pulse.
- o_result_out_en, out, 1, result read pulse.
- o_counter, out, 8, phase counter.
- o_busy, out, 1, compute or result-wait in progress.
- o_valid, out, 1, result available.
- o_err, out, 1, sticky protocol error.
- o_irq, out, 1, done pulse.

Function
REQ-003 Address map (relative to BASE_ADDR, decoded only when i_valid=1):
- 0x10: status read.
- 0x20: result read.
- 0x30: clear error.
- 0x100+4k: weight write to lane k.
- 0x200+4k: activation write to lane k.
- k < N_LANES; any other k is undecoded.
REQ-004 The block SHALL implement an FSM with four states: IDLE, ACT, COMP, RES.
REQ-005 IDLE: a weight beat SHALL assert o_weight_in_en combinationally in the same cycle and register o_weight_sel=k.
REQ-006 Weight beats SHALL increment the weight beat counter. On the WORDS_PER_WL-th beat, o_weight_out_en SHALL pulse for 1 cycle in the next cycle and the beat counter SHALL return to 0.
REQ-007 o_WL_address SHALL increment in the cycle after each o_weight_out_en pulse, wrapping from WL_DEPTH-1 to 0.
REQ-008 In IDLE or ACT, an activation beat SHALL assert o_activation_in_en combinationally and register o_activation_sel=k. In IDLE it SHALL also transition to ACT.
REQ-009 ACT SHALL count activation beats. The ACT_WORDS-th beat SHALL cause a transition to COMP on the next cycle, with o_counter reset to 0.
REQ-010 COMP SHALL increment o_counter every cycle. o_activation_out_en SHALL pulse in the cycle after each cycle where o_counter%ACT_STRIDE == ACT_STRIDE-1.
REQ-011 After COMP_CYCLES cycles, COMP SHALL transition to RES with o_counter reset to 0.
REQ-012 RES SHALL last RES_LAT cycles. o_result_in_en SHALL pulse on the last RES cycle.
REQ-013 The cycle after the o_result_in_en pulse, the block SHALL:
- set o_valid;
- pulse o_irq for 1 cycle;
- return to IDLE.
REQ-014 A result read with o_valid=1 SHALL pulse o_result_out_en exactly 1 cycle later and clear o_valid in the same cycle as that pulse.
REQ-015 A result read with o_valid=0 SHALL set o_err and SHALL NOT pulse o_result_out_en.
REQ-016 o_busy SHALL be combinational, equal to 1 in COMP or RES.
REQ-017 In COMP or RES, any weight or activation write SHALL be ignored: no in_en, no counter change, and o_err set.
REQ-018 A weight write in ACT SHALL be ignored and SHALL set o_err.
REQ-019 An undecoded address inside the window SHALL set o_err. Addresses outside the window SHALL have no effect.
REQ-020 An error-clear access SHALL clear o_err. If an error event occurs in the same cycle as the clear, o_err SHALL remain set.
REQ-021 A new o_result_in_en while o_valid=1 SHALL overwrite: o_valid stays 1 and o_err is set (overrun).
REQ-022 In IDLE and ACT, o_counter SHALL report the respective beat counter.
REQ-023 The counter SHALL saturate at 8'hFF and SHALL NOT wrap.

Reset
REQ-024 i_rst_n=0 at a clock edge SHALL:
- clear all outputs to 0;
- clear all counters to 0;
- clear o_WL_address to 0;
- force the FSM to IDLE.
REQ-025 Reset asserted mid-phase SHALL abort the operation. No pulse outputs SHALL fire in the cycle after reset release.

Verification
REQ-026 16 weight writes to lane 2 -> o_weight_sel=2; a single o_weight_out_en pulse after beat 16; o_WL_address 0 -> 1.
REQ-027 288*16 weight writes -> 288 out_en pulses; o_WL_address wraps 287 -> 0.
REQ-028 72 activation writes -> COMP for 64 cycles with 8 o_activation_out_en pulses; o_busy=1 for 72 cycles; o_result_in_en on the last RES cycle; o_valid=1 and o_irq pulse the cycle after.
REQ-029 Result read after o_valid -> o_result_out_en 1 cycle later; o_valid=0. A second read -> o_err=1 and no out_en.
REQ-030 A weight write during COMP -> o_err=1 and o_weight_in_en=0. A clear -> o_err=0.
REQ-031 i_rst_n=0 at COMP cycle 30 -> IDLE; all outputs 0; o_busy=0 the next cycle.
